// File: rtl/imem_loader_if.sv
// Host byte stream, instruction memory write port and core/status lines of the program loader.
interface imem_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  // master = loader side, slave = host / memory / core side
  modport master (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
  );

  modport slave (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a length-prefixed host byte stream into big-endian words and writes them to imem.
// Latency: 4th byte of a word accepted at edge k, imem_we high in cycle k+1; 5 cycles/word sustained.
// Backpressure: in_ready low outside LEN_HI/LEN_LO/DATA, so the host holds its byte through WRITE.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Largest legal word count; 17 bits so 2**16 still fits.
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

  state_t      state;
  state_t      next_state;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;

  assign xfer      = bus.in_valid & bus.in_ready;
  assign len_full  = {len[15:8], bus.in_data};
  assign last_word = (word_cnt == len - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)                next_state = S_DONE;
          else if ({1'b0, len_full} > MAX_LEN)  next_state = S_ERR;
          else                                  next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && byte_cnt == 2'd3) next_state = S_WRITE;
      end
      S_WRITE: begin
        next_state = last_word ? S_DONE : S_DATA;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.imem_we  = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.cpu_hold = 1'b1;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      S_WRITE: begin
        bus.busy    = 1'b1;
        bus.imem_we = 1'b1;
      end
      S_DONE: begin
        bus.done     = 1'b1;
        bus.cpu_hold = 1'b0;
      end
      S_ERR: begin
        bus.err = 1'b1;
      end
      default: ;
    endcase
  end

  // Length, word packing and word/byte counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= 16'd0;
      word_cnt <= 16'd0;
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else begin
      case (state)
        S_LEN_HI: begin
          if (xfer) len[15:8] <= bus.in_data;
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= bus.in_data;
            word_cnt <= 16'd0;
            byte_cnt <= 2'd0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            word     <= {word[23:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          if (!last_word) begin
            word_cnt <= word_cnt + 16'd1;
            byte_cnt <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // word_cnt only advances after the WRITE cycle, so the address is stable while imem_we is high.
  assign bus.imem_addr  = {14'd0, word_cnt, 2'b00};
  assign bus.imem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives host bytes on the falling edge, samples outputs there too.
module tb_imem_loader;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   we_total;
  int   base;
  logic [31:0] last_addr;
  logic [31:0] mem [0:255];

  imem_loader_if bus ();

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory image and write counter seen by the instruction memory.
  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) begin
      mem[bus.imem_addr[9:2]] <= bus.imem_wdata;
      last_addr               <= bus.imem_addr;
      we_total                <= we_total + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

  // Called on a falling edge; returns on the falling edge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte_timeout got in_ready=%b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_hold got %b want 1", bus.cpu_hold); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    vectors++; if ({bus.done, bus.err, bus.busy, bus.imem_we} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {bus.done, bus.err, bus.busy, bus.imem_we}); end
    vectors++; if ({bus.imem_addr, bus.imem_wdata} !== 64'd0) begin miscompares++; $display("FAIL reset_bus got %h want 0", {bus.imem_addr, bus.imem_wdata}); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset got ready=%b busy=%b want 0 0", bus.in_ready, bus.busy); end
  endtask

  task automatic test_basic();
    base = we_total;
    pulse_start();
    vectors++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_len_hi got busy=%b ready=%b want 1 1", bus.busy, bus.in_ready); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    vectors++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 32'h0 || bus.imem_wdata !== 32'h20080005) begin miscompares++; $display("FAIL basic_write0 got we=%b addr=%h data=%h want 1 00000000 20080005", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    send_byte(8'hAC); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
    vectors++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 32'h4 || bus.imem_wdata !== 32'hAC080000) begin miscompares++; $display("FAIL basic_write1 got we=%b addr=%h data=%h want 1 00000004 ac080000", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    @(negedge clk);
    vectors++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.imem_we !== 1'b0) begin miscompares++; $display("FAIL basic_done got done=%b hold=%b we=%b want 1 0 0", bus.done, bus.cpu_hold, bus.imem_we); end
    vectors++; if (we_total - base !== 2) begin miscompares++; $display("FAIL basic_we_count got %0d want 2", we_total - base); end
    vectors++; if (mem[0] !== 32'h20080005 || mem[1] !== 32'hAC080000) begin miscompares++; $display("FAIL basic_image got %h %h want 20080005 ac080000", mem[0], mem[1]); end
  endtask

  task automatic test_empty();
    base = we_total;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h00;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL empty_start_ready got %b want 0", bus.in_ready); end
    @(negedge clk);
    bus.start = 1'b0;
    vectors++; if (bus.done !== 1'b0 || bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL empty_rearm got done=%b hold=%b want 0 1", bus.done, bus.cpu_hold); end
    send_byte(8'h00); send_byte(8'h00);
    vectors++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0) begin miscompares++; $display("FAIL empty_done got done=%b hold=%b want 1 0", bus.done, bus.cpu_hold); end
    vectors++; if (we_total - base !== 0) begin miscompares++; $display("FAIL empty_no_write got %0d want 0", we_total - base); end
  endtask

  task automatic test_err();
    base = we_total;
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    vectors++; if (bus.err !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL err_flag got err=%b hold=%b busy=%b want 1 1 0", bus.err, bus.cpu_hold, bus.busy); end
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0 || bus.err !== 1'b1) begin miscompares++; $display("FAIL err_holds got ready=%b err=%b want 0 1", bus.in_ready, bus.err); end
    bus.in_valid = 1'b0;
    pulse_start();
    vectors++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL err_clear got err=%b busy=%b want 0 1", bus.err, bus.busy); end
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    vectors++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 32'h0 || bus.imem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL err_reload_write got we=%b addr=%h data=%h want 1 00000000 deadbeef", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    @(negedge clk);
    vectors++; if (bus.done !== 1'b1 || bus.err !== 1'b0 || we_total - base !== 1) begin miscompares++; $display("FAIL err_reload_done got done=%b err=%b writes=%0d want 1 0 1", bus.done, bus.err, we_total - base); end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [0:9];
    bytes = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    base = we_total;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(bytes[i]);
      if (i == 3) begin
        pulse_start();
        vectors++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin miscompares++; $display("FAIL gaps_start_ignored got busy=%b done=%b want 1 0", bus.busy, bus.done); end
      end
    end
    // Present the next byte during the WRITE cycle: it must wait one cycle.
    bus.in_valid = 1'b1;
    bus.in_data = bytes[6];
    vectors++; if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b1) begin miscompares++; $display("FAIL gaps_write_stall got ready=%b we=%b want 0 1", bus.in_ready, bus.imem_we); end
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1 || bus.imem_we !== 1'b0) begin miscompares++; $display("FAIL gaps_resume got ready=%b we=%b want 1 0", bus.in_ready, bus.imem_we); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 7; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(bytes[i]);
    end
    @(negedge clk);
    vectors++; if (bus.done !== 1'b1 || we_total - base !== 2) begin miscompares++; $display("FAIL gaps_done got done=%b writes=%0d want 1 2", bus.done, we_total - base); end
    vectors++; if (mem[0] !== 32'h20080005 || mem[1] !== 32'hAC080000) begin miscompares++; $display("FAIL gaps_image got %h %h want 20080005 ac080000", mem[0], mem[1]); end
  endtask

  task automatic test_full_length();
    logic [7:0] b;
    base = we_total;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    vectors++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL full_accepted got err=%b busy=%b want 0 1", bus.err, bus.busy); end
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      send_byte(b); send_byte(8'h5A); send_byte(~b); send_byte(8'hC3);
    end
    @(negedge clk);
    vectors++; if (bus.done !== 1'b1 || we_total - base !== 256) begin miscompares++; $display("FAIL full_done got done=%b writes=%0d want 1 256", bus.done, we_total - base); end
    vectors++; if (last_addr !== 32'h3FC) begin miscompares++; $display("FAIL full_last_addr got %h want 000003fc", last_addr); end
    vectors++; if (mem[0] !== 32'h005AFFC3 || mem[128] !== 32'h805A7FC3 || mem[255] !== 32'hFF5A00C3) begin miscompares++; $display("FAIL full_image got %h %h %h want 005affc3 805a7fc3 ff5a00c3", mem[0], mem[128], mem[255]); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h99); send_byte(8'h88);
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL async_reset got hold=%b busy=%b ready=%b want 1 0 0", bus.cpu_hold, bus.busy, bus.in_ready); end
    vectors++; if (bus.imem_wdata !== 32'h0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL async_reset_data got wdata=%h done=%b want 0 0", bus.imem_wdata, bus.done); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = we_total;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    vectors++; if (bus.done !== 1'b1 || we_total - base !== 1 || last_addr !== 32'h0) begin miscompares++; $display("FAIL async_restart got done=%b writes=%0d addr=%h want 1 1 0", bus.done, we_total - base, last_addr); end
    vectors++; if (mem[0] !== 32'h11223344) begin miscompares++; $display("FAIL async_restart_image got %h want 11223344", mem[0]); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    we_total = 0;
    test_reset();
    test_basic();
    test_empty();
    test_err();
    test_gaps();
    test_full_length();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
